// File: rtl/sd_regs_pkg.sv
// sd_regs_pkg: register map offsets, fixed read values and reset defaults for the SD Wishbone register bank
package sd_regs_pkg;

    localparam logic [7:0] OFF_ARG     = 8'h00;
    localparam logic [7:0] OFF_CMD     = 8'h04;
    localparam logic [7:0] OFF_RESP0   = 8'h08;
    localparam logic [7:0] OFF_RESP1   = 8'h0C;
    localparam logic [7:0] OFF_RESP2   = 8'h10;
    localparam logic [7:0] OFF_RESP3   = 8'h14;
    localparam logic [7:0] OFF_CTRL    = 8'h1C;
    localparam logic [7:0] OFF_TIMEOUT = 8'h20;
    localparam logic [7:0] OFF_CLKDIV  = 8'h24;
    localparam logic [7:0] OFF_SRST    = 8'h28;
    localparam logic [7:0] OFF_VOLT    = 8'h2C;
    localparam logic [7:0] OFF_CAPA    = 8'h30;
    localparam logic [7:0] OFF_CISR    = 8'h34;
    localparam logic [7:0] OFF_CISER   = 8'h38;
    localparam logic [7:0] OFF_DISR    = 8'h3C;
    localparam logic [7:0] OFF_DISER   = 8'h40;
    localparam logic [7:0] OFF_BLKSIZE = 8'h44;
    localparam logic [7:0] OFF_BLKCNT  = 8'h48;
    localparam logic [7:0] OFF_DMA     = 8'h60;

    localparam logic [31:0] VOLTAGE_VAL     = 32'h0000_000F;
    localparam logic [31:0] CAPABILITY_VAL  = 32'h0000_0000;
    localparam logic [7:0]  RST_CLK_DIV_DEF = 8'hFF;
    localparam logic [11:0] RST_BLKSIZE_DEF = 12'h200;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/sd_wb_regbank_if.sv
// sd_wb_regbank_if: Wishbone classic slave bus bundle for the SD register bank
interface sd_wb_regbank_if #(parameter int AW = 8);
    logic [AW-1:0] wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [31:0]   wb_dat_o;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic          wb_ack_o;
    logic          wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/sd_int_reg.sv
// sd_int_reg: sticky W1C interrupt status, enable register and registered level irq
module sd_int_reg #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] evt,
    input  logic [W-1:0] clr,
    input  logic         ier_we,
    input  logic [W-1:0] ier_d,
    output logic [W-1:0] isr,
    output logic [W-1:0] ier,
    output logic         irq
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isr <= '0;
            ier <= '0;
            irq <= 1'b0;
        end else begin
            // a new event wins over a same-cycle clear
            isr <= (isr & ~clr) | evt;
            if (ier_we) ier <= ier_d;
            irq <= |(isr & ier);
        end
    end

endmodule

// File: rtl/sd_wb_regbank.sv
// sd_wb_regbank: Wishbone-mapped SD controller register bank with command/data interrupt blocks
module sd_wb_regbank
    import sd_regs_pkg::*;
#(
    parameter int                   AW          = 8,
    parameter int                   INT_CMD_W   = 5,
    parameter int                   INT_DATA_W  = 3,
    parameter int                   BLKSIZE_W   = 12,
    parameter int                   BLKCNT_W    = 16,
    parameter logic [7:0]           RST_CLK_DIV = RST_CLK_DIV_DEF,
    parameter logic [BLKSIZE_W-1:0] RST_BLKSIZE = BLKSIZE_W'(RST_BLKSIZE_DEF)
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    sd_wb_regbank_if.slave        wb,
    output logic                  cmd_start_o,
    output logic                  soft_rst_o,
    output logic [31:0]           argument_o,
    output logic [15:0]           command_o,
    output logic [15:0]           controller_o,
    output logic [15:0]           timeout_o,
    output logic [7:0]            clock_div_o,
    output logic [BLKSIZE_W-1:0]  block_size_o,
    output logic [BLKCNT_W-1:0]   block_count_o,
    output logic [31:0]           dma_addr_o,
    input  logic [31:0]           resp0_i,
    input  logic [31:0]           resp1_i,
    input  logic [31:0]           resp2_i,
    input  logic [31:0]           resp3_i,
    input  logic [INT_CMD_W-1:0]  cmd_evt_i,
    input  logic [INT_DATA_W-1:0] data_evt_i,
    input  logic                  cmd_busy_i,
    output logic                  cmd_irq_o,
    output logic                  data_irq_o
);

    logic [AW-1:0]         adr;
    logic                  req, wr, mapped, unused_adr;
    logic [31:0]           rdata, wmask, wd;
    logic [INT_CMD_W-1:0]  cmd_isr, cmd_iser;
    logic [INT_DATA_W-1:0] data_isr, data_iser;

    assign adr        = {wb.wb_adr_i[AW-1:2], 2'b00};
    assign unused_adr = ^wb.wb_adr_i[1:0];
    // a request is only taken while no response is showing, giving the ack/idle toggle
    assign req   = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o & ~wb.wb_err_o;
    assign wr    = req & wb.wb_we_i;
    assign wmask = lane_mask(wb.wb_sel_i);
    assign wd    = wb.wb_dat_i & wmask;

    function automatic logic at(input logic [7:0] off);
        return wr && adr == AW'(off);
    endfunction

    always_comb begin
        rdata  = '0;
        mapped = 1'b1;
        case (adr)
            AW'(OFF_ARG):     rdata = argument_o;
            AW'(OFF_CMD):     rdata = 32'(command_o);
            AW'(OFF_RESP0):   rdata = resp0_i;
            AW'(OFF_RESP1):   rdata = resp1_i;
            AW'(OFF_RESP2):   rdata = resp2_i;
            AW'(OFF_RESP3):   rdata = resp3_i;
            AW'(OFF_CTRL):    rdata = 32'(controller_o);
            AW'(OFF_TIMEOUT): rdata = 32'(timeout_o);
            AW'(OFF_CLKDIV):  rdata = 32'(clock_div_o);
            AW'(OFF_SRST):    rdata = '0;
            AW'(OFF_VOLT):    rdata = VOLTAGE_VAL;
            AW'(OFF_CAPA):    rdata = CAPABILITY_VAL;
            AW'(OFF_CISR):    rdata = 32'(cmd_isr);
            AW'(OFF_CISER):   rdata = 32'(cmd_iser);
            AW'(OFF_DISR):    rdata = 32'(data_isr);
            AW'(OFF_DISER):   rdata = 32'(data_iser);
            AW'(OFF_BLKSIZE): rdata = 32'(block_size_o);
            AW'(OFF_BLKCNT):  rdata = 32'(block_count_o);
            AW'(OFF_DMA):     rdata = dma_addr_o;
            default:          mapped = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wb.wb_ack_o   <= 1'b0;
            wb.wb_err_o   <= 1'b0;
            wb.wb_dat_o   <= '0;
            cmd_start_o   <= 1'b0;
            soft_rst_o    <= 1'b0;
            argument_o    <= '0;
            command_o     <= '0;
            controller_o  <= '0;
            timeout_o     <= '0;
            clock_div_o   <= RST_CLK_DIV;
            block_size_o  <= RST_BLKSIZE;
            block_count_o <= '0;
            dma_addr_o    <= '0;
        end else begin
            wb.wb_ack_o <= req & mapped;
            wb.wb_err_o <= req & ~mapped;
            wb.wb_dat_o <= (req & mapped & ~wb.wb_we_i) ? rdata : '0;
            cmd_start_o <= at(OFF_ARG) & ~cmd_busy_i;
            soft_rst_o  <= at(OFF_SRST) & wd[0];
            // argument is frozen while a command is in flight
            if (at(OFF_ARG) && !cmd_busy_i) argument_o <= (argument_o & ~wmask) | wd;
            if (at(OFF_CMD)) command_o <= (command_o & ~wmask[15:0]) | wd[15:0];
            if (at(OFF_CTRL)) controller_o <= (controller_o & ~wmask[15:0]) | wd[15:0];
            if (at(OFF_TIMEOUT)) timeout_o <= (timeout_o & ~wmask[15:0]) | wd[15:0];
            if (at(OFF_CLKDIV)) clock_div_o <= (clock_div_o & ~wmask[7:0]) | wd[7:0];
            if (at(OFF_BLKSIZE)) block_size_o <= (block_size_o & ~wmask[BLKSIZE_W-1:0]) | wd[BLKSIZE_W-1:0];
            if (at(OFF_BLKCNT)) block_count_o <= (block_count_o & ~wmask[BLKCNT_W-1:0]) | wd[BLKCNT_W-1:0];
            if (at(OFF_DMA)) dma_addr_o <= (dma_addr_o & ~wmask) | wd;
        end
    end

    sd_int_reg #(.W(INT_CMD_W)) u_cmd_int (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .evt    (cmd_evt_i),
        .clr    ({INT_CMD_W{at(OFF_CISR)}} & wd[INT_CMD_W-1:0]),
        .ier_we (at(OFF_CISER)),
        .ier_d  ((cmd_iser & ~wmask[INT_CMD_W-1:0]) | wd[INT_CMD_W-1:0]),
        .isr    (cmd_isr),
        .ier    (cmd_iser),
        .irq    (cmd_irq_o)
    );

    sd_int_reg #(.W(INT_DATA_W)) u_data_int (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .evt    (data_evt_i),
        .clr    ({INT_DATA_W{at(OFF_DISR)}} & wd[INT_DATA_W-1:0]),
        .ier_we (at(OFF_DISER)),
        .ier_d  ((data_iser & ~wmask[INT_DATA_W-1:0]) | wd[INT_DATA_W-1:0]),
        .isr    (data_isr),
        .ier    (data_iser),
        .irq    (data_irq_o)
    );

endmodule

// File: tb/tb_sd_wb_regbank.sv
// tb_sd_wb_regbank: random and directed bus traffic against a register-map model, responses checked by a scoreboard
module tb_sd_wb_regbank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_start_o, soft_rst_o, cmd_irq_o, data_irq_o, cmd_busy_i;
    logic [31:0] argument_o, dma_addr_o, resp0_i, resp1_i, resp2_i, resp3_i;
    logic [15:0] command_o, controller_o, timeout_o;
    logic [7:0]  clock_div_o;
    logic [11:0] block_size_o;
    logic [15:0] block_count_o;
    logic [4:0]  cmd_evt_i;
    logic [2:0]  data_evt_i;

    always #5 clk = ~clk;

    sd_wb_regbank_if #(.AW(8)) wb ();

    sd_wb_regbank dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .wb            (wb),
        .cmd_start_o   (cmd_start_o),
        .soft_rst_o    (soft_rst_o),
        .argument_o    (argument_o),
        .command_o     (command_o),
        .controller_o  (controller_o),
        .timeout_o     (timeout_o),
        .clock_div_o   (clock_div_o),
        .block_size_o  (block_size_o),
        .block_count_o (block_count_o),
        .dma_addr_o    (dma_addr_o),
        .resp0_i       (resp0_i),
        .resp1_i       (resp1_i),
        .resp2_i       (resp2_i),
        .resp3_i       (resp3_i),
        .cmd_evt_i     (cmd_evt_i),
        .data_evt_i    (data_evt_i),
        .cmd_busy_i    (cmd_busy_i),
        .cmd_irq_o     (cmd_irq_o),
        .data_irq_o    (data_irq_o)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic        chk_data;
        logic        start;
        logic        srst;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   total = 0;
    int   bad = 0;

    // reference register file, values kept at their architectural widths
    logic [31:0] m_arg, m_cmd, m_ctrl, m_tmo, m_clk, m_cisr, m_cier, m_disr, m_dier, m_bsz, m_bcnt, m_dma;

    task automatic model_reset();
        m_arg = 0; m_cmd = 0; m_ctrl = 0; m_tmo = 0; m_clk = 32'hFF;
        m_cisr = 0; m_cier = 0; m_disr = 0; m_dier = 0;
        m_bsz = 32'h200; m_bcnt = 0; m_dma = 0;
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    function automatic logic is_mapped(input logic [7:0] a);
        return (a & 8'hFC) inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h1C, 8'h20, 8'h24,
                                   8'h28, 8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C, 8'h40, 8'h44, 8'h48, 8'h60};
    endfunction

    function automatic logic [31:0] mread(input logic [7:0] a);
        case (a & 8'hFC)
            8'h00: return m_arg;
            8'h04: return m_cmd;
            8'h08: return resp0_i;
            8'h0C: return resp1_i;
            8'h10: return resp2_i;
            8'h14: return resp3_i;
            8'h1C: return m_ctrl;
            8'h20: return m_tmo;
            8'h24: return m_clk;
            8'h2C: return 32'h0000_000F;
            8'h34: return m_cisr;
            8'h38: return m_cier;
            8'h3C: return m_disr;
            8'h40: return m_dier;
            8'h44: return m_bsz;
            8'h48: return m_bcnt;
            8'h60: return m_dma;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] upd(input logic [31:0] old, d, m, wmax);
        return ((old & ~m) | (d & m)) & wmax;
    endfunction

    task automatic model_apply(input logic we, input logic [7:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic busy, input logic [4:0] ce, input logic [2:0] de);
        logic [31:0] m, cc, dc;
        m = bmask(s); cc = 0; dc = 0;
        if (we) begin
            case (a & 8'hFC)
                8'h00: if (!busy) m_arg = upd(m_arg, d, m, 32'hFFFF_FFFF);
                8'h04: m_cmd  = upd(m_cmd, d, m, 32'hFFFF);
                8'h1C: m_ctrl = upd(m_ctrl, d, m, 32'hFFFF);
                8'h20: m_tmo  = upd(m_tmo, d, m, 32'hFFFF);
                8'h24: m_clk  = upd(m_clk, d, m, 32'hFF);
                8'h34: cc = d & m;
                8'h38: m_cier = upd(m_cier, d, m, 32'h1F);
                8'h3C: dc = d & m;
                8'h40: m_dier = upd(m_dier, d, m, 32'h7);
                8'h44: m_bsz  = upd(m_bsz, d, m, 32'hFFF);
                8'h48: m_bcnt = upd(m_bcnt, d, m, 32'hFFFF);
                8'h60: m_dma  = upd(m_dma, d, m, 32'hFFFF_FFFF);
                default: ;
            endcase
        end
        m_cisr = (m_cisr & ~cc & 32'h1F) | 32'(ce);
        m_disr = (m_disr & ~dc & 32'h7) | 32'(de);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_arg"}, argument_o, m_arg);
        chk({tag, "_cmd"}, 32'(command_o), m_cmd);
        chk({tag, "_ctrl"}, 32'(controller_o), m_ctrl);
        chk({tag, "_tmo"}, 32'(timeout_o), m_tmo);
        chk({tag, "_clkdiv"}, 32'(clock_div_o), m_clk);
        chk({tag, "_bsz"}, 32'(block_size_o), m_bsz);
        chk({tag, "_bcnt"}, 32'(block_count_o), m_bcnt);
        chk({tag, "_dma"}, dma_addr_o, m_dma);
        chk({tag, "_cirq"}, 32'(cmd_irq_o), 32'((m_cisr & m_cier) != 0));
        chk({tag, "_dirq"}, 32'(data_irq_o), 32'((m_disr & m_dier) != 0));
    endtask

    task automatic bus_idle();
        wb.wb_cyc_i = 0; wb.wb_stb_i = 0; wb.wb_we_i = 0;
        wb.wb_adr_i = 0; wb.wb_dat_i = 0; wb.wb_sel_i = 0;
        cmd_busy_i = 0; cmd_evt_i = 0; data_evt_i = 0;
    endtask

    task automatic xfer(input logic we, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic busy, input logic [4:0] ce, input logic [2:0] de);
        exp_t e;
        logic got;
        @(posedge clk);
        @(negedge clk);
        e.err      = !is_mapped(a);
        e.data     = (!we && is_mapped(a)) ? mread(a) : 0;
        e.chk_data = !we;
        e.start    = we && (a & 8'hFC) == 8'h00 && !busy;
        e.srst     = we && (a & 8'hFC) == 8'h28 && s[0] && d[0];
        sb.push_back(e);
        model_apply(we, a, d, s, busy, ce, de);
        wb.wb_cyc_i = 1; wb.wb_stb_i = 1; wb.wb_we_i = we;
        wb.wb_adr_i = a; wb.wb_dat_i = d; wb.wb_sel_i = s;
        cmd_busy_i = busy; cmd_evt_i = ce; data_evt_i = de;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            cmd_evt_i = 0; data_evt_i = 0;
            got = wb.wb_ack_o | wb.wb_err_o;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL timeout adr=%h got=no_response exp=ack_or_err", a);
            sb.delete(sb.size() - 1);
        end
        bus_idle();
    endtask

    task automatic pulse_evt(input logic [4:0] ce, input logic [2:0] de);
        @(negedge clk);
        model_apply(0, 8'h00, 0, 0, 0, ce, de);
        cmd_evt_i = ce; data_evt_i = de;
        @(posedge clk);
        #1;
        cmd_evt_i = 0; data_evt_i = 0;
    endtask

    task automatic stall_read(input logic [7:0] a);
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        e.err = 0; e.data = mread(a); e.chk_data = 1; e.start = 0; e.srst = 0;
        sb.push_back(e);
        sb.push_back(e);
        wb.wb_cyc_i = 1; wb.wb_stb_i = 1; wb.wb_we_i = 0; wb.wb_adr_i = a; wb.wb_sel_i = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // monitor: every response the DUT presents is matched against the oldest expectation
    always @(negedge clk) begin
        if (wb.wb_ack_o || wb.wb_err_o) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_resp got=ack%b_err%b exp=none", wb.wb_ack_o, wb.wb_err_o);
            end else begin
                me = sb.pop_front();
                chk("resp_kind", {30'd0, wb.wb_ack_o, wb.wb_err_o}, {30'd0, !me.err, me.err});
                if (me.chk_data) chk("rdata", wb.wb_dat_o, me.data);
                chk("cmd_start", 32'(cmd_start_o), 32'(me.start));
                chk("soft_rst", 32'(soft_rst_o), 32'(me.srst));
            end
        end else begin
            chk("idle_outputs", {wb.wb_dat_o[29:0], cmd_start_o, soft_rst_o}, 32'd0);
        end
    end

    initial begin
        bus_idle();
        resp0_i = 0; resp1_i = 0; resp2_i = 0; resp3_i = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("in_reset");
        rst_n = 1;
        settle();
        check_all("reset");
        chk("reset_ack", {30'd0, wb.wb_ack_o, wb.wb_err_o}, 32'd0);

        xfer(1, 8'h00, 32'h01020304, 4'hF, 0, 0, 0);
        check_all("arg");
        chk("arg_const", argument_o, 32'h01020304);
        xfer(1, 8'h00, 32'hDEADBEEF, 4'hF, 1, 0, 0);
        chk("arg_busy_kept", argument_o, 32'h01020304);

        xfer(1, 8'h60, 32'h11121314, 4'hF, 0, 0, 0);
        xfer(1, 8'h60, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        chk("dma_lanes", dma_addr_o, 32'h11BB13DD);

        xfer(1, 8'h38, 32'h02, 4'hF, 0, 0, 0);
        pulse_evt(5'h1A, 3'h0);
        xfer(0, 8'h34, 0, 4'hF, 0, 0, 0);
        settle();
        chk("cirq_on", 32'(cmd_irq_o), 32'd1);
        xfer(1, 8'h34, 32'h02, 4'hF, 0, 0, 0);
        xfer(0, 8'h34, 0, 4'hF, 0, 0, 0);
        settle();
        chk("cirq_off", 32'(cmd_irq_o), 32'd0);
        chk("cisr_model", m_cisr, 32'h18);

        xfer(0, 8'h2C, 0, 4'hF, 0, 0, 0);
        xfer(0, 8'h50, 0, 4'hF, 0, 0, 0);
        xfer(1, 8'h50, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        stall_read(8'h2C);

        xfer(1, 8'h40, 32'h1, 4'hF, 0, 0, 0);
        pulse_evt(5'h0, 3'h1);
        xfer(1, 8'h3C, 32'h1, 4'hF, 0, 0, 3'h1);
        xfer(0, 8'h3C, 0, 4'hF, 0, 0, 0);
        settle();
        chk("disr_same_cycle", m_disr, 32'h1);
        chk("dirq_on", 32'(data_irq_o), 32'd1);

        xfer(1, 8'h28, 32'h1, 4'h1, 0, 0, 0);
        xfer(1, 8'h2C, 32'h1234, 4'hF, 0, 0, 0);
        xfer(0, 8'h2C, 0, 4'hF, 0, 0, 0);

        resp0_i = $urandom; resp1_i = $urandom; resp2_i = $urandom; resp3_i = $urandom;
        for (int i = 0; i < 4; i++) xfer(0, 8'(8 + 4 * i), 0, 4'hF, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            xfer($urandom_range(0, 1), 8'($urandom_range(0, 111)), $urandom, 4'($urandom),
                 $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0,
                 ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'h0);
            if (i % 50 == 49) begin
                settle();
                check_all("rand");
            end
        end
        settle();
        check_all("rand_end");

        // reset arriving while ack is showing
        @(negedge clk);
        wb.wb_cyc_i = 1; wb.wb_stb_i = 1; wb.wb_we_i = 1;
        wb.wb_adr_i = 8'h60; wb.wb_dat_i = 32'h5555_5555; wb.wb_sel_i = 4'hF;
        @(posedge clk);
        #1;
        chk("midrst_ack_before", 32'(wb.wb_ack_o), 32'd1);
        rst_n = 0;
        #1;
        chk("midrst_ack_drop", {30'd0, wb.wb_ack_o, wb.wb_err_o}, 32'd0);
        bus_idle();
        model_reset();
        check_all("midrst");
        @(posedge clk);
        #1;
        rst_n = 1;
        settle();
        check_all("after_rst");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
